// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the program counter, drives the instruction
// memory address, and loads the IF/ID register consumed by decode. Applies
// hazard stalls and branch-redirect flushes, and counts both kinds of event
// with saturating counters.
module ifetch_unit #(
  parameter int                XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = 32'h0,
  parameter int                CNT_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stall_i,
  input  logic              branch_taken_i,
  input  logic [XLEN-1:0]   branch_target_i,
  output logic [XLEN-1:0]   imem_addr_o,
  input  logic [31:0]       imem_data_i,
  output logic [XLEN-1:0]   pc_o,
  output logic [XLEN-1:0]   ifid_pc_o,
  output logic [31:0]       ifid_instr_o,
  output logic              ifid_valid_o,
  output logic              flush_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   ifid_pc;
  logic [31:0]       ifid_instr;
  logic              ifid_valid;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  // Redirect target is forced word-aligned; the next sequential PC wraps mod 2^XLEN.
  logic [XLEN-1:0]   branch_pc;
  logic [XLEN-1:0]   next_seq_pc;

  assign branch_pc   = {branch_target_i[XLEN-1:2], 2'b00};
  assign next_seq_pc = pc + XLEN'(4);

  assign imem_addr_o  = pc;
  assign pc_o         = pc;
  assign ifid_pc_o    = ifid_pc;
  assign ifid_instr_o = ifid_instr;
  assign ifid_valid_o = ifid_valid;
  assign stall_cnt_o  = stall_cnt;
  assign flush_cnt_o  = flush_cnt;
  assign flush_o      = (state == RUN) ? branch_taken_i : 1'b0;

  // Fetch FSM: state, PC, IF/ID register and event counters all update here.
  // A state-change edge does no fetch; it leaves IF/ID holding a bubble.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      ifid_pc    <= '0;
      ifid_instr <= '0;
      ifid_valid <= 1'b0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          ifid_pc    <= '0;
          ifid_instr <= '0;
          ifid_valid <= 1'b0;
          if (start_i) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (!start_i) begin
            state      <= IDLE;
            ifid_pc    <= '0;
            ifid_instr <= '0;
            ifid_valid <= 1'b0;
          end else if (branch_taken_i) begin
            pc         <= branch_pc;
            ifid_pc    <= '0;
            ifid_instr <= '0;
            ifid_valid <= 1'b0;
            if (flush_cnt != '1) begin
              flush_cnt <= flush_cnt + CNT_W'(1);
            end
          end else if (stall_i) begin
            if (stall_cnt != '1) begin
              stall_cnt <= stall_cnt + CNT_W'(1);
            end
          end else begin
            pc         <= next_seq_pc;
            ifid_pc    <= pc;
            ifid_instr <= imem_data_i;
            ifid_valid <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit. Instance a uses default parameters and a
// small instruction ROM; instance b uses 4-bit counters and a reset PC at the
// top of the address space to exercise counter saturation and PC wrap.
module tb_ifetch_unit;

  logic        clk;

  // Instance a signals
  logic        rstA, startA, stallA, branchA;
  logic [31:0] targetA, addrA, dataA, pcA, ifidPcA, ifidInstrA;
  logic        validA, flushA;
  logic [31:0] stallCntA, flushCntA;

  // Instance b signals
  logic        rstB, startB, stallB, branchB;
  logic [31:0] targetB, addrB, dataB, pcB, ifidPcB, ifidInstrB;
  logic        validB, flushB;
  logic [3:0]  stallCntB, flushCntB;

  logic [31:0] imem [0:31];

  int checks = 0;
  int errors = 0;

  ifetch_unit #(.XLEN(32), .RESET_PC(32'h0), .CNT_W(32)) dutA (
    .clk_i(clk), .rst_i(rstA), .start_i(startA), .stall_i(stallA),
    .branch_taken_i(branchA), .branch_target_i(targetA),
    .imem_addr_o(addrA), .imem_data_i(dataA), .pc_o(pcA),
    .ifid_pc_o(ifidPcA), .ifid_instr_o(ifidInstrA), .ifid_valid_o(validA),
    .flush_o(flushA), .stall_cnt_o(stallCntA), .flush_cnt_o(flushCntA)
  );

  ifetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .CNT_W(4)) dutB (
    .clk_i(clk), .rst_i(rstB), .start_i(startB), .stall_i(stallB),
    .branch_taken_i(branchB), .branch_target_i(targetB),
    .imem_addr_o(addrB), .imem_data_i(dataB), .pc_o(pcB),
    .ifid_pc_o(ifidPcB), .ifid_instr_o(ifidInstrB), .ifid_valid_o(validB),
    .flush_o(flushB), .stall_cnt_o(stallCntB), .flush_cnt_o(flushCntB)
  );

  // Combinational instruction memory; addresses outside the ROM return a marker
  assign dataA = (addrA[31:7] == 25'd0) ? imem[addrA[6:2]] : 32'hDEAD_BEEF;
  // Instance b always reads an all-zero word to show zero is latched as valid
  assign dataB = 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) imem[i] = 32'h1000_0000 | (i * 4);
    imem[0] = 32'h0050_0093;
    imem[1] = 32'h00A0_0113;
    imem[2] = 32'h0020_81B3;

    rstA = 1; startA = 0; stallA = 0; branchA = 0; targetA = 0;
    rstB = 1; startB = 0; stallB = 0; branchB = 0; targetB = 0;
    #2;

    // Reset state
    applyStimulus(1);
    checkOutput("rst_pc",        pcA,        32'h0);
    checkOutput("rst_ifid_pc",   ifidPcA,    32'h0);
    checkOutput("rst_ifid_ins",  ifidInstrA, 32'h0);
    checkOutput("rst_valid",     {31'd0, validA}, 32'd0);
    checkOutput("rst_stall_cnt", stallCntA,  32'd0);
    checkOutput("rst_flush_cnt", flushCntA,  32'd0);
    checkOutput("rst_imem_addr", addrA,      32'h0);

    // IDLE->RUN edge does no fetch
    rstA = 0; startA = 1;
    applyStimulus(1);
    checkOutput("start_pc",    pcA,             32'h0);
    checkOutput("start_valid", {31'd0, validA}, 32'd0);

    // Sequential fetch
    applyStimulus(1);
    checkOutput("f0_pc",    ifidPcA,    32'h0);
    checkOutput("f0_ins",   ifidInstrA, 32'h0050_0093);
    checkOutput("f0_valid", {31'd0, validA}, 32'd1);
    checkOutput("f0_next",  pcA,        32'h4);
    applyStimulus(1);
    checkOutput("f1_pc",   ifidPcA,    32'h4);
    checkOutput("f1_ins",  ifidInstrA, 32'h00A0_0113);
    checkOutput("f1_next", pcA,        32'h8);

    // Two stall cycles at pc 8
    stallA = 1;
    applyStimulus(1);
    checkOutput("st1_pc",  pcA,       32'h8);
    checkOutput("st1_cnt", stallCntA, 32'd1);
    applyStimulus(1);
    checkOutput("st2_pc",   pcA,        32'h8);
    checkOutput("st2_ifid", ifidPcA,    32'h4);
    checkOutput("st2_ins",  ifidInstrA, 32'h00A0_0113);
    checkOutput("st2_cnt",  stallCntA,  32'd2);
    stallA = 0;
    applyStimulus(1);
    checkOutput("res_pc",   ifidPcA,    32'h8);
    checkOutput("res_ins",  ifidInstrA, 32'h0020_81B3);
    checkOutput("res_next", pcA,        32'hC);

    // Branch taken at pc 12 to 0x20
    branchA = 1; targetA = 32'h20;
    #1;
    checkOutput("br_flush_o", {31'd0, flushA}, 32'd1);
    applyStimulus(1);
    checkOutput("br_pc",    pcA,             32'h20);
    checkOutput("br_ins",   ifidInstrA,      32'h0);
    checkOutput("br_valid", {31'd0, validA}, 32'd0);
    checkOutput("br_cnt",   flushCntA,       32'd1);
    branchA = 0;
    #1;
    checkOutput("br_flush_lo", {31'd0, flushA}, 32'd0);
    applyStimulus(1);
    checkOutput("tgt_pc",  ifidPcA,    32'h20);
    checkOutput("tgt_ins", ifidInstrA, 32'h1000_0020);
    checkOutput("tgt_next", pcA,       32'h24);

    // Stall and branch together: branch wins, target aligned
    stallA = 1; branchA = 1; targetA = 32'h43;
    applyStimulus(1);
    checkOutput("sb_pc",    pcA,       32'h40);
    checkOutput("sb_flush", flushCntA, 32'd2);
    checkOutput("sb_stall", stallCntA, 32'd2);
    stallA = 0; branchA = 0;
    applyStimulus(1);
    checkOutput("sb_ifid", ifidPcA,    32'h40);
    checkOutput("sb_ins",  ifidInstrA, 32'h1000_0040);
    checkOutput("sb_next", pcA,        32'h44);

    // start_i low for three cycles; requests in IDLE are ignored
    startA = 0;
    applyStimulus(1);
    checkOutput("stop_pc",    pcA,             32'h44);
    checkOutput("stop_valid", {31'd0, validA}, 32'd0);
    stallA = 1; branchA = 1; targetA = 32'h80;
    #1;
    checkOutput("idle_flush_o", {31'd0, flushA}, 32'd0);
    applyStimulus(2);
    checkOutput("idle_pc",    pcA,             32'h44);
    checkOutput("idle_ifid",  ifidPcA,         32'h0);
    checkOutput("idle_ins",   ifidInstrA,      32'h0);
    checkOutput("idle_stall", stallCntA,       32'd2);
    checkOutput("idle_flush", flushCntA,       32'd2);

    // Reset with branch and start asserted: reset wins
    rstA = 1; startA = 1; branchA = 1; stallA = 1; targetA = 32'h80;
    applyStimulus(1);
    checkOutput("mr_pc",    pcA,       32'h0);
    checkOutput("mr_stall", stallCntA, 32'd0);
    checkOutput("mr_flush", flushCntA, 32'd0);
    rstA = 0; branchA = 0; stallA = 0;
    applyStimulus(1);
    checkOutput("mr_idle_pc",    pcA,             32'h0);
    checkOutput("mr_idle_valid", {31'd0, validA}, 32'd0);
    applyStimulus(1);
    checkOutput("mr_fetch_ins", ifidInstrA, 32'h0050_0093);

    // Instance b: counter saturation and PC wrap
    rstB = 0; startB = 1;
    applyStimulus(1);
    checkOutput("b_start_pc", pcB, 32'hFFFF_FFFC);
    stallB = 1;
    applyStimulus(20);
    checkOutput("b_sat_cnt", {28'd0, stallCntB}, 32'd15);
    checkOutput("b_sat_pc",  pcB,                32'hFFFF_FFFC);
    stallB = 0;
    applyStimulus(1);
    checkOutput("b_wrap_pc",    pcB,             32'h0);
    checkOutput("b_wrap_ifid",  ifidPcB,         32'hFFFF_FFFC);
    checkOutput("b_zero_ins",   ifidInstrB,      32'h0);
    checkOutput("b_zero_valid", {31'd0, validB}, 32'd1);
    checkOutput("b_flush_cnt",  {28'd0, flushCntB}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage of the five-stage pipelined CPU. Owns the program counter, drives the instruction-memory read address, and loads the IF/ID pipeline register consumed by decode. Applies hazard-unit stalls and branch-redirect flushes. Keeps hardware stall and flush event counters that match the counts the system bench reports.

## Interface
- XLEN, 32, datapath and PC width
- RESET_PC, 32'h0, PC value loaded on reset
- CNT_W, 32, width of each event counter
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset, synchronous, active-high
- start_i  in  1  run enable (level); fetch advances only while in RUN
- stall_i  in  1  hazard-detection stall request: hold PC and IF/ID
- branch_taken_i  in  1  branch resolved taken in ID: redirect and flush
- branch_target_i  in  XLEN  redirect address
- imem_addr_o  out  XLEN  instruction-memory byte address, combinational, equal to pc_o
- imem_data_i  in  32  instruction word, combinational read of imem_addr_o
- pc_o  out  XLEN  current PC register
- ifid_pc_o  out  XLEN  PC of the instruction held in IF/ID
- ifid_instr_o  out  32  instruction held in IF/ID; 32'h0 marks a bubble
- ifid_valid_o  out  1  IF/ID holds a real instruction
- flush_o  out  1  combinational; equals branch_taken_i while state is RUN, otherwise 0
- stall_cnt_o  out  CNT_W  count of stall cycles
- flush_cnt_o  out  CNT_W  count of flush cycles

## Operation
- FSM states:
  - IDLE: state after reset.
  - RUN.
  - IDLE→RUN on an edge where start_i=1.
  - RUN→IDLE on an edge where start_i=0.
  - The transition edge itself performs no fetch.
- Reset (rst_i=1 at an edge) overrides every other input, including branch_taken_i and stall_i. Register values after reset:
  - pc_o=RESET_PC, ifid_pc_o=0, ifid_instr_o=0, ifid_valid_o=0
  - stall_cnt_o=0, flush_cnt_o=0
  - state=IDLE
- In IDLE:
  - PC holds.
  - IF/ID is loaded with a bubble: pc 0, instruction 0, valid 0.
  - stall_i and branch_taken_i are ignored; counters hold.
- In RUN, exactly one action per edge, in this priority order:
  - branch_taken_i=1 (stall_i is ignored):
    - pc <= {branch_target_i[XLEN-1:2], 2'b00}
    - IF/ID <= bubble
    - flush_cnt_o increments
  - else stall_i=1:
    - pc and IF/ID hold their values
    - stall_cnt_o increments
  - else (normal fetch):
    - pc <= pc+4
    - ifid_pc_o <= pc, ifid_instr_o <= imem_data_i, ifid_valid_o <= 1
- Arithmetic:
  - pc+4 is modulo 2^XLEN; 32'hFFFFFFFC advances to 0 with no flag.
  - Counters saturate at 2^CNT_W-1 and do not wrap.
- An instruction word of 32'h0 fetched in normal flow is latched with valid=1. Decode treats it as a no-op.

## Timing
- imem_addr_o and flush_o are combinational from current state. All other outputs are registered.
- Fetch latency: the instruction at address A appears on ifid_instr_o the edge after pc_o=A is presented, if no stall or branch occurs on that edge.
- A stall holds the pipeline for exactly the cycles stall_i is high. Fetch resumes at the same PC on the first edge with stall_i low.
- A branch taken at edge N:
  - pc_o=target after N.
  - IF/ID is a bubble after N.
  - The target instruction is in IF/ID after N+1, if no stall occurs.
  - Branch penalty: one bubble.
- Simultaneous stall_i and branch_taken_i: the branch wins. Only flush_cnt_o increments.
- Reset asserted mid-run takes effect at that edge. Stall or flush requests on that same edge are not counted.

## Test plan
- Reset then run:
  - Stimulus: rst_i=1 for 1 edge, start_i=1, imem words 0x00500093, 0x00A00113, 0x002081B3 at addresses 0, 4, 8, no stall or branch.
  - Required: ifid_pc_o/ifid_instr_o = 0/0x00500093, then 4/0x00A00113, then 8/0x002081B3 on successive edges after the IDLE→RUN edge; pc_o reaches 12.
- Stall:
  - Stimulus: stall_i=1 for 2 edges while pc_o=8.
  - Required: pc_o stays 8, IF/ID unchanged, stall_cnt_o=2, then fetch resumes at 8.
- Branch:
  - Stimulus: branch_taken_i=1, branch_target_i=0x20 while pc_o=12.
  - Required: flush_o=1 in that cycle. Next edge: pc_o=0x20, ifid_instr_o=0, ifid_valid_o=0, flush_cnt_o=1. Following edge: ifid_pc_o=0x20.
- Simultaneous stall and branch:
  - Stimulus: stall_i=1 and branch_taken_i=1 with target 0x43.
  - Required: pc_o=0x40, flush_cnt_o increments, stall_cnt_o unchanged.
- Start deassert and reset mid-run:
  - Stimulus: start_i=0 for 3 cycles, then rst_i=1 together with branch_taken_i=1.
  - Required while start_i=0: pc_o holds, IF/ID becomes a bubble, counters hold.
  - Required after the reset edge: pc_o=RESET_PC, both counters 0, state IDLE.
- Saturation and wrap:
  - Stimulus: CNT_W=4 with 20 stall cycles; separately, pc_o=32'hFFFFFFFC with a normal fetch.
  - Required: stall_cnt_o=15; pc_o wraps to 0.
